// File: rtl/sdram_refresh_scheduler_pkg.sv
// Shared SDRAM timing package.
// Holds the default refresh timing constants used by the controller, the
// init sequencer and the refresh scheduler, plus the pending-counter
// update encoding used inside the scheduler.
package sdram_refresh_scheduler_pkg;

   // 7.8 us at 100 MHz between AUTO REFRESH credits
   localparam int SDRAM_REFRESH_CYCLES       = 780;
   // JEDEC allows up to 8 refreshes to be postponed
   localparam int SDRAM_MAX_PENDING_REFRESH  = 8;
   // Escalate before the postponement budget is exhausted
   localparam int SDRAM_URGENT_THRESHOLD     = 6;

   // Net effect of one edge on the pending counter (before saturation)
   typedef enum logic [1:0] {
      PEND_HOLD = 2'd0,
      PEND_INC  = 2'd1,
      PEND_DEC  = 2'd2
   } pend_op_e;

endpackage

// File: rtl/sdram_refresh_scheduler_timer.sv
// refresh_interval_timer: reloadable down-counter that produces one
// terminal-count tick every REFRESH_CYCLES enabled clocks.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous, active-high; loads REFRESH_CYCLES-1
//   enable  - count when high; reload (no tick) when low
//   tick    - high during the cycle whose edge sees the count at 0
module refresh_interval_timer #(
   parameter int REFRESH_CYCLES = 780
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int              W      = $clog2(REFRESH_CYCLES);
   localparam logic [W-1:0]    RELOAD = W'(REFRESH_CYCLES - 1);

   logic [W-1:0] count;

   // Tick is combinational so the pending counter consumes it on the same
   // edge the timer reloads; this keeps credits exactly REFRESH_CYCLES apart.
   assign tick = enable && (count == '0);

   always_ff @(posedge clock) begin
      if (reset || !enable)
         count <= RELOAD;
      else if (count == '0)
         count <= RELOAD;
      else
         count <= count - 1'b1;
   end

endmodule

// File: rtl/sdram_refresh_scheduler.sv
// sdram_refresh_scheduler: tracks owed SDRAM auto-refreshes.
// A timer credits one refresh every REFRESH_CYCLES enabled clocks; the
// controller retires them with refresh_ack pulses. The owed count saturates
// at both ends; losing a credit at saturation sets a sticky overflow flag.
// Ports:
//   clock          - rising-edge clock
//   reset          - synchronous, active-high
//   enable         - init done; low clears pending and halts the timer
//   refresh_ack    - one pulse per AUTO REFRESH issued (counts per cycle)
//   refresh_req    - level: at least one refresh owed
//   refresh_urgent - owed count >= URGENT_THRESHOLD
//   pending        - owed-refresh count
//   overflow       - sticky, cleared only by reset
module sdram_refresh_scheduler
   import sdram_refresh_scheduler_pkg::*;
#(
   parameter int REFRESH_CYCLES   = SDRAM_REFRESH_CYCLES,
   parameter int MAX_PENDING      = SDRAM_MAX_PENDING_REFRESH,
   parameter int URGENT_THRESHOLD = SDRAM_URGENT_THRESHOLD
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               enable,
   input  logic                               refresh_ack,
   output logic                               refresh_req,
   output logic                               refresh_urgent,
   output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
   output logic                               overflow
);

   localparam int           PW      = $clog2(MAX_PENDING + 1);
   localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);
   localparam logic [PW-1:0] PEND_URG = PW'(URGENT_THRESHOLD);

   logic     tick;
   pend_op_e op;

   refresh_interval_timer #(
      .REFRESH_CYCLES (REFRESH_CYCLES)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .tick   (tick)
   );

   // A credit and an ack on the same edge cancel, even at either limit,
   // so neither saturation nor overflow can trigger in that case.
   always_comb begin
      op = PEND_HOLD;
      if (tick && !refresh_ack)
         op = PEND_INC;
      else if (!tick && refresh_ack)
         op = PEND_DEC;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pending  <= '0;
         overflow <= 1'b0;
      end else if (!enable) begin
         pending  <= '0;
      end else begin
         case (op)
            PEND_INC: begin
               if (pending == PEND_MAX)
                  overflow <= 1'b1;
               else
                  pending  <= pending + 1'b1;
            end
            PEND_DEC: begin
               // Stray ack with nothing owed is harmless; just ignore it
               if (pending != '0)
                  pending <= pending - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign refresh_req    = (pending != '0);
   assign refresh_urgent = (pending >= PEND_URG);

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
module tb_sdram_refresh_scheduler;

   localparam int RC  = 10;
   localparam int MAXP = 4;
   localparam int URG = 3;
   localparam int PW  = $clog2(MAXP + 1);

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          refresh_ack = 1'b0;
   logic          refresh_req;
   logic          refresh_urgent;
   logic [PW-1:0] pending;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   sdram_refresh_scheduler #(
      .REFRESH_CYCLES   (RC),
      .MAX_PENDING      (MAXP),
      .URGENT_THRESHOLD (URG)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .refresh_ack    (refresh_ack),
      .refresh_req    (refresh_req),
      .refresh_urgent (refresh_urgent),
      .pending        (pending),
      .overflow       (overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic rst;
      logic en;
      logic ack;
      int   reps;
      int   p;
      logic req;
      logic urg;
      logic ovf;
   } vec_t;

   vec_t vecs[28];

   function automatic vec_t mk(logic rst, logic en, logic ack, int reps,
                               int p, logic req, logic urg, logic ovf);
      vec_t v;
      v.rst = rst; v.en = en; v.ack = ack; v.reps = reps;
      v.p = p; v.req = req; v.urg = urg; v.ovf = ovf;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int p, input logic req,
                          input logic urg, input logic ovf);
      chk({tag, ".pending"}, int'(pending), p);
      chk({tag, ".req"}, int'(refresh_req), int'(req));
      chk({tag, ".urgent"}, int'(refresh_urgent), int'(urg));
      chk({tag, ".overflow"}, int'(overflow), int'(ovf));
   endtask

   // Apply inputs for one edge, sample 1 time unit after it
   task automatic step(input logic r, input logic e, input logic a);
      reset = r; enable = e; refresh_ack = a;
      @(posedge clock);
      #1;
   endtask

   // Independent reference model for the random phase
   int m_timer, m_p;
   logic m_ovf;

   task automatic model_step(input logic r, input logic e, input logic a);
      logic t;
      t = e && (m_timer == 0);
      if (r) begin
         m_timer = RC - 1; m_p = 0; m_ovf = 1'b0;
      end else if (!e) begin
         m_timer = RC - 1; m_p = 0;
      end else begin
         m_timer = (m_timer == 0) ? RC - 1 : m_timer - 1;
         if (t && !a) begin
            if (m_p == MAXP) m_ovf = 1'b1;
            else m_p = m_p + 1;
         end else if (!t && a && m_p > 0) begin
            m_p = m_p - 1;
         end
      end
   endtask

   initial begin
      // {rst, en, ack, reps, pending, req, urgent, overflow} after the last rep
      vecs[0]  = mk(1, 0, 0,  2, 0, 0, 0, 0); // reset
      vecs[1]  = mk(0, 1, 0,  9, 0, 0, 0, 0); // edges 1..9: nothing yet
      vecs[2]  = mk(0, 1, 0,  1, 1, 1, 0, 0); // edge 10: first credit
      vecs[3]  = mk(0, 1, 0, 10, 2, 1, 0, 0); // edge 20
      vecs[4]  = mk(0, 1, 1,  1, 1, 1, 0, 0); // ack drain
      vecs[5]  = mk(0, 1, 1,  1, 0, 0, 0, 0); // req drops after 2nd ack
      vecs[6]  = mk(1, 1, 0,  1, 0, 0, 0, 0); // restart
      vecs[7]  = mk(0, 1, 0, 29, 2, 1, 0, 0); // edge 29
      vecs[8]  = mk(0, 1, 0,  1, 3, 1, 1, 0); // edge 30: urgent
      vecs[9]  = mk(0, 1, 0, 10, 4, 1, 1, 0); // edge 40: full
      vecs[10] = mk(0, 1, 0,  9, 4, 1, 1, 0); // edge 49: no overflow yet
      vecs[11] = mk(0, 1, 0,  1, 4, 1, 1, 1); // edge 50: overflow
      vecs[12] = mk(0, 1, 0,  9, 4, 1, 1, 1); // edge 59
      vecs[13] = mk(0, 1, 1,  1, 4, 1, 1, 1); // tick+ack at max: hold
      vecs[14] = mk(0, 0, 0,  1, 0, 0, 0, 1); // disable keeps overflow
      vecs[15] = mk(0, 1, 1,  1, 0, 0, 0, 1); // ack at 0 ignored
      vecs[16] = mk(0, 1, 0,  9, 1, 1, 0, 1);
      vecs[17] = mk(0, 1, 0,  9, 1, 1, 0, 1);
      vecs[18] = mk(0, 1, 0,  1, 2, 1, 0, 1);
      vecs[19] = mk(0, 1, 0,  9, 2, 1, 0, 1); // timer now 0
      vecs[20] = mk(0, 1, 1,  1, 2, 1, 0, 1); // tick+ack at 2: hold
      vecs[21] = mk(0, 1, 0,  6, 2, 1, 0, 1); // timer now 3
      vecs[22] = mk(0, 0, 0,  1, 0, 0, 0, 1); // abort: pending cleared
      vecs[23] = mk(0, 1, 0,  9, 0, 0, 0, 1); // timer reloaded
      vecs[24] = mk(0, 1, 0,  1, 1, 1, 0, 1); // credit 10 edges later
      vecs[25] = mk(0, 1, 0,  4, 1, 1, 0, 1); // mid-interval
      vecs[26] = mk(1, 1, 0,  1, 0, 0, 0, 0); // reset clears overflow too
      vecs[27] = mk(0, 1, 0, 10, 1, 1, 0, 0); // timer restarted by reset

      for (int i = 0; i < 28; i++) begin
         for (int k = 0; k < vecs[i].reps; k++)
            step(vecs[i].rst, vecs[i].en, vecs[i].ack);
         chk_all($sformatf("vec%0d", i), vecs[i].p, vecs[i].req,
                 vecs[i].urg, vecs[i].ovf);
      end

      // Multi-cycle ack counts once per cycle, saturating at 0
      begin
         int n;
         step(1, 0, 0);
         n = 0;
         while (pending != PW'(2) && n < 40) begin
            step(0, 1, 0);
            n++;
         end
         chk("wait_pending2", int'(pending), 2);
         chk("wait_cycles", n, 2 * RC);
         step(0, 1, 1); chk("hold_ack1", int'(pending), 1);
         step(0, 1, 1); chk("hold_ack2", int'(pending), 0);
         step(0, 1, 1); chk("hold_ack3", int'(pending), 0);
         chk("hold_ack_req", int'(refresh_req), 0);
      end

      // Randomised run against the reference model
      step(1, 0, 0);
      m_timer = RC - 1; m_p = 0; m_ovf = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         logic r, e, a;
         r = ($urandom_range(0, 99) < 2);
         e = ($urandom_range(0, 99) < 92);
         a = ($urandom_range(0, 99) < 9);
         model_step(r, e, a);
         step(r, e, a);
         chk_all($sformatf("rnd%0d", c), m_p, m_p != 0, m_p >= URG, m_ovf);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
